// File: rtl/logic_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module   : logic_table_sweeper
// Purpose  : Bitwise two-input boolean function selected by a 4-bit truth
//            table, with a self-running sweep that captures the table.
// Revision : 1.0 - initial release
// ============================================================================
module logic_table_sweeper #(
    parameter int WIDTH = 4,
    parameter int HOLD  = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [3:0]       func,
    input  logic             mode,
    input  logic             start,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] s,
    output logic             valid_out,
    output logic             busy,
    output logic             done,
    output logic [3:0]       table_out,
    output logic [1:0]       step
);

    localparam int c_HCW = (HOLD < 1) ? 1 : $clog2(HOLD + 1);
    localparam logic [c_HCW-1:0] c_HOLD_LAST = c_HCW'(HOLD - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_func_q,   w_func_q_nxt;
    logic [c_HCW-1:0] r_hold,     w_hold_nxt;
    logic [3:0]       r_tbl_cap,  w_tbl_cap_nxt;
    logic [WIDTH-1:0] r_s,        w_s_nxt;
    logic             r_valid,    w_valid_nxt;
    logic             r_busy,     w_busy_nxt;
    logic             r_done,     w_done_nxt;
    logic [3:0]       r_table,    w_table_nxt;
    logic [1:0]       r_step,     w_step_nxt;
    logic [1:0]       w_step_inc;

    assign w_step_inc = r_step + 2'd1;

    function automatic logic [WIDTH-1:0] eval_tt(
        input logic [3:0]       tt,
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y
    );
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = tt[{x[i], y[i]}];
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= ST_IDLE;
            r_func_q  <= 4'd0;
            r_hold    <= '0;
            r_tbl_cap <= 4'd0;
            r_s       <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_table   <= 4'd0;
            r_step    <= 2'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_func_q  <= w_func_q_nxt;
            r_hold    <= w_hold_nxt;
            r_tbl_cap <= w_tbl_cap_nxt;
            r_s       <= w_s_nxt;
            r_valid   <= w_valid_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_table   <= w_table_nxt;
            r_step    <= w_step_nxt;
        end
    end

    // Each step's result is loaded on the edge that enters the step, so
    // valid_out lines up with the first cycle that step shows that index.
    always_comb begin
        w_state_nxt   = r_state;
        w_func_q_nxt  = r_func_q;
        w_hold_nxt    = r_hold;
        w_tbl_cap_nxt = r_tbl_cap;
        w_s_nxt       = r_s;
        w_valid_nxt   = 1'b0;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_table_nxt   = r_table;
        w_step_nxt    = r_step;

        case (r_state)
            ST_IDLE: begin
                if (mode && start) begin
                    w_state_nxt   = ST_SWEEP;
                    w_func_q_nxt  = func;
                    w_hold_nxt    = '0;
                    w_step_nxt    = 2'd0;
                    w_busy_nxt    = 1'b1;
                    w_s_nxt       = {WIDTH{func[0]}};
                    w_valid_nxt   = 1'b1;
                    w_tbl_cap_nxt = {3'b000, func[0]};
                end else if (valid_in) begin
                    w_s_nxt     = eval_tt(func, a, b);
                    w_valid_nxt = 1'b1;
                end
            end

            ST_SWEEP: begin
                if (r_hold == c_HOLD_LAST) begin
                    w_hold_nxt = '0;
                    if (r_step == 2'd3) begin
                        w_state_nxt = ST_DONE;
                        w_step_nxt  = 2'd0;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_table_nxt = r_tbl_cap;
                    end else begin
                        w_step_nxt                = w_step_inc;
                        w_s_nxt                   = {WIDTH{r_func_q[w_step_inc]}};
                        w_valid_nxt               = 1'b1;
                        w_tbl_cap_nxt[w_step_inc] = r_func_q[w_step_inc];
                    end
                end else begin
                    w_hold_nxt = r_hold + 1'b1;
                end
            end

            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_step_nxt  = 2'd0;
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
                w_step_nxt  = 2'd0;
            end
        endcase
    end

    assign s         = r_s;
    assign valid_out = r_valid;
    assign busy      = r_busy;
    assign done      = r_done;
    assign table_out = r_table;
    assign step      = r_step;

endmodule
`default_nettype wire
